tag_resolver: RTL and testbench

TAG_RESOLVER -- requirements
Module: tag_resolver

---
 rtl/tag_resolver_if.sv | 27 ++
 rtl/tag_resolver.sv | 94 +++++++++
 tb/tb_tag_resolver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/tag_resolver_if.sv
// Handshake bundle between a tag register consumer and the tag resolver.
// The master drives the snapshot request and acceptance; the slave presents responders.
interface tag_resolver_if #(
  parameter int N     = 100,
  parameter int IDX_W = 7
);
  logic [N-1:0]     tag_wires;
  logic             load;
  logic             flush;
  logic             ready;
  logic             valid;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] remaining;
  logic             some_none;
  logic             busy;
  logic             done;

  modport master (
    output tag_wires, load, flush, ready,
    input  valid, index, remaining, some_none, busy, done
  );

  modport slave (
    input  tag_wires, load, flush, ready,
    output valid, index, remaining, some_none, busy, done
  );
endinterface

// File: rtl/tag_resolver.sv
// Snapshots a tag vector and enumerates its responders lowest-index first,
// one per accepted handshake, with a single-cycle done pulse at the end.
module tag_resolver #(
  parameter int N     = 100,
  parameter int IDX_W = 7
) (
  input  logic         CLK,
  input  logic         RST,
  tag_resolver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRESENT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     pending_reg, pending_next;
  logic [IDX_W-1:0] remaining_reg, remaining_next;
  logic             some_none_reg, some_none_next;

  logic [IDX_W-1:0] lowest_idx;
  logic [IDX_W-1:0] tag_count;
  logic             valid_int;

  // Descending scan so the lowest set bit is the final assignment.
  always_comb begin
    lowest_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_reg[i]) lowest_idx = IDX_W'(i);
    end
  end

  always_comb begin
    tag_count = '0;
    for (int i = 0; i < N; i++) begin
      tag_count = tag_count + IDX_W'(bus.tag_wires[i]);
    end
  end

  always_comb begin
    state_next     = state_reg;
    pending_next   = pending_reg;
    remaining_next = remaining_reg;
    some_none_next = some_none_reg;
    valid_int      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.load && !bus.flush) begin
          pending_next   = bus.tag_wires;
          remaining_next = tag_count;
          some_none_next = |bus.tag_wires;
          state_next     = (|bus.tag_wires) ? PRESENT : DONE;
        end
      end
      PRESENT: begin
        valid_int = 1'b1;
        if (bus.flush) begin
          pending_next   = '0;
          remaining_next = '0;
          state_next     = DONE;
        end else if (bus.ready) begin
          // x & (x-1) drops exactly the lowest set bit, i.e. the presented index.
          pending_next   = pending_reg & (pending_reg - N'(1));
          remaining_next = remaining_reg - IDX_W'(1);
          if (remaining_reg == IDX_W'(1)) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      pending_reg   <= '0;
      remaining_reg <= '0;
      some_none_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      remaining_reg <= remaining_next;
      some_none_reg <= some_none_next;
    end
  end

  assign bus.valid     = valid_int;
  assign bus.index     = valid_int ? lowest_idx : '0;
  assign bus.remaining = remaining_reg;
  assign bus.some_none = some_none_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
endmodule

// File: tb/tb_tag_resolver.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-based model of the responder enumeration.
module tb_tag_resolver;
  localparam int N     = 100;
  localparam int IDX_W = 7;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  tag_resolver_if #(.N(N), .IDX_W(IDX_W)) bus ();

  tag_resolver #(.N(N), .IDX_W(IDX_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 presenting, 2 done.
  int model_phase = 0;
  int model_q[$];
  bit model_some = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit ld, input bit fl, input bit rdy,
                            input logic [N-1:0] tags);
    if (r) begin
      model_phase = 0;
      model_q.delete();
      model_some = 1'b0;
    end else begin
      case (model_phase)
        0: if (ld && !fl) begin
          model_q.delete();
          for (int i = 0; i < N; i++) if (tags[i]) model_q.push_back(i);
          model_some = (model_q.size() > 0);
          model_phase = (model_q.size() > 0) ? 1 : 2;
          $display("load responders=%0d", model_q.size());
        end
        1: if (fl) begin
          model_q.delete();
          model_phase = 2;
          $display("flush");
        end else if (rdy) begin
          $display("accept index=%0d remaining=%0d", model_q[0], model_q.size());
          void'(model_q.pop_front());
          if (model_q.size() == 0) model_phase = 2;
        end
        default: model_phase = 0;
      endcase
    end
  endtask

  task automatic check_outputs();
    bit   exp_valid;
    int   exp_index;
    exp_valid = (model_phase == 1);
    exp_index = exp_valid ? model_q[0] : 0;
    check_val("valid", 32'(bus.valid), 32'(exp_valid));
    check_val("index", 32'(bus.index), 32'(exp_index));
    check_val("remaining", 32'(bus.remaining), 32'(model_q.size()));
    check_val("some_none", 32'(bus.some_none), 32'(model_some));
    check_val("busy", 32'(bus.busy), 32'(model_phase != 0));
    check_val("done", 32'(bus.done), 32'(model_phase == 2));
  endtask

  task automatic cycle(input bit r, input bit ld, input bit fl, input bit rdy,
                       input logic [N-1:0] tags);
    @(negedge CLK);
    RST           = r;
    bus.load      = ld;
    bus.flush     = fl;
    bus.ready     = rdy;
    bus.tag_wires = tags;
    @(posedge CLK);
    model_step(r, ld, fl, rdy, tags);
    #1;
    check_outputs();
  endtask

  function automatic logic [N-1:0] bits3(input int a, input int b, input int c);
    logic [N-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [N-1:0] t;
    logic [N-1:0] all_ones;
    all_ones = '1;
    bus.load = 1'b0; bus.flush = 1'b0; bus.ready = 1'b0; bus.tag_wires = '0;

    // Reset with load/flush/ready asserted: reset must win.
    cycle(1, 1, 1, 1, all_ones);
    cycle(1, 0, 0, 0, '0);

    // Three sparse responders including the top bit.
    cycle(0, 1, 0, 1, bits3(3, 17, 99));
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1, '0);

    // Empty snapshot goes straight to DONE.
    cycle(0, 1, 0, 1, '0);
    for (int k = 0; k < 2; k++) cycle(0, 0, 0, 1, '0);

    // Back-pressure, with ignored reloads while presenting.
    cycle(0, 1, 0, 0, bits3(0, 5, -1));
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, bits3(40, 41, 42));
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, '0);

    // Every tag line set.
    cycle(0, 1, 0, 1, all_ones);
    for (int k = 0; k < 102; k++) cycle(0, 0, 0, 1, '0);

    // Flush after the first acceptance; same-cycle ready is not an acceptance.
    cycle(0, 1, 0, 1, bits3(10, 20, 30));
    cycle(0, 0, 0, 1, '0);
    cycle(0, 0, 1, 1, '0);
    for (int k = 0; k < 2; k++) cycle(0, 0, 0, 1, '0);

    // Flush and load together in IDLE: no snapshot.
    cycle(0, 1, 1, 1, bits3(1, 2, 3));
    cycle(0, 0, 0, 1, '0);

    // Reset while index 20 is presented, then a normal load.
    cycle(0, 1, 0, 1, bits3(10, 20, 30));
    cycle(0, 0, 0, 1, '0);
    cycle(0, 0, 0, 0, '0);
    cycle(1, 0, 0, 1, '0);
    cycle(0, 0, 0, 0, '0);
    cycle(0, 1, 0, 1, bits3(7, -1, -1));
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, '0);

    // Randomized traffic with varying density and rare resets/flushes.
    for (int k = 0; k < 4000; k++) begin
      int dens;
      dens = $urandom_range(0, 3);
      t = '0;
      if (dens != 0) begin
        for (int i = 0; i < N; i++)
          t[i] = ($urandom_range(0, (dens == 1) ? 40 : (dens == 2) ? 6 : 1) == 0);
      end
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) < 7),
            t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
